// File: rtl/neur_pkg.sv
// Shared types and constants for the neuron result drain sequencer.
package neur_pkg;

   localparam int LANES = 4;
   localparam int WIDTH = 32;

   // Lane 0 occupies the most significant word of the bank.
   localparam int LANE_TOP = LANES - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   // Extract lane k from a top-first bank; indices past the bank read as zero.
   function automatic logic [WIDTH-1:0] lane_word(input logic [LANES*WIDTH-1:0] bank,
                                                  input logic [2:0]             k);
      logic [WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < LANES; i++) begin
         if (k == 3'(i)) w = bank[(LANE_TOP - i)*WIDTH +: WIDTH];
      end
      return w;
   endfunction

endpackage

// File: rtl/neur_out_fmt.sv
// Combinational formatter: builds one writeback word from the bank at a lane position.
module neur_out_fmt
   import neur_pkg::*;
(
   input  logic [LANES*WIDTH-1:0] bank_i,
   input  logic [2:0]             pos_i,
   input  logic                   relu_i,
   input  logic                   compress_i,
   input  logic [2:0]             n_i,
   output logic [WIDTH-1:0]       word_o
);

   logic [2:0]       lo_pos;
   logic [WIDTH-1:0] hi_lane;
   logic [WIDTH-1:0] lo_lane;

   // Select and rectify the lane at pos and its neighbour; pack when compressing.
   always_comb begin
      lo_pos  = pos_i + 3'd1;
      hi_lane = lane_word(bank_i, pos_i);
      lo_lane = lane_word(bank_i, lo_pos);
      if (relu_i && hi_lane[WIDTH-1]) hi_lane = '0;
      if (relu_i && lo_lane[WIDTH-1]) lo_lane = '0;
      if (lo_pos >= n_i)              lo_lane = '0;
      if (compress_i) word_o = {hi_lane[15:0], lo_lane[15:0]};
      else            word_o = hi_lane;
   end

endmodule

// File: rtl/neur_out_seq.sv
// Drain sequencer: streams a latched four-lane result bank out as formatted words.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start_i; outputs quiet
//   S_DRAIN | presenting words on the valid/ready stream
//   S_DONE  | one-cycle done_o pulse after the final transfer
module neur_out_seq
   import neur_pkg::*;
#(
   parameter int LANES = 4,
   parameter int WIDTH = 32
)(
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [LANES*WIDTH-1:0] results_i,
   input  logic [1:0]             n_lanes_i,
   input  logic                   relu_i,
   input  logic                   compress_i,
   input  logic                   flush_i,
   output logic                   out_valid_o,
   output logic [WIDTH-1:0]       out_data_o,
   input  logic                   out_ready_i,
   output logic                   busy_o,
   output logic                   done_o
);

   state_e                 state_q, state_d;
   logic [2:0]             pos_q, pos_d;
   logic                   valid_q, valid_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic [LANES*WIDTH-1:0] bank_q;
   logic [1:0]             nraw_q;
   logic                   relu_q, comp_q;
   logic                   latch_en;

   logic [2:0]             n_dec;
   logic [2:0]             pos_nxt;
   logic                   xfer, last;
   logic [LANES*WIDTH-1:0] fmt_bank;
   logic [2:0]             fmt_pos, fmt_n;
   logic                   fmt_relu, fmt_comp;
   logic [WIDTH-1:0]       fmt_word;

   // The formatter always looks one word ahead: from IDLE it sees the incoming
   // bank at lane 0, so word 0 can be registered on the same edge that accepts start.
   always_comb begin
      n_dec   = (nraw_q == 2'd0) ? 3'd4 : {1'b0, nraw_q};
      pos_nxt = pos_q + (comp_q ? 3'd2 : 3'd1);
      xfer    = valid_q && out_ready_i;
      last    = (pos_nxt >= n_dec);
      if (state_q == S_IDLE) begin
         fmt_bank = results_i;
         fmt_pos  = 3'd0;
         fmt_n    = (n_lanes_i == 2'd0) ? 3'd4 : {1'b0, n_lanes_i};
         fmt_relu = relu_i;
         fmt_comp = compress_i;
      end else begin
         fmt_bank = bank_q;
         fmt_pos  = pos_nxt;
         fmt_n    = n_dec;
         fmt_relu = relu_q;
         fmt_comp = comp_q;
      end
   end

   neur_out_fmt u_fmt (
      .bank_i     (fmt_bank),
      .pos_i      (fmt_pos),
      .relu_i     (fmt_relu),
      .compress_i (fmt_comp),
      .n_i        (fmt_n),
      .word_o     (fmt_word)
   );

   // Next-state logic; flush overrides any transfer, and a coinciding word still counts as taken.
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      valid_d  = valid_q;
      data_d   = data_q;
      latch_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               state_d  = S_DRAIN;
               pos_d    = 3'd0;
               valid_d  = 1'b1;
               data_d   = fmt_word;
               latch_en = 1'b1;
            end
         end
         S_DRAIN: begin
            if (flush_i) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               data_d  = '0;
            end else if (xfer) begin
               pos_d = pos_nxt;
               if (last) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  data_d  = '0;
               end else begin
                  data_d = fmt_word;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            data_d  = '0;
         end
      endcase
   end

   // State, stream register and drain configuration latches.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         pos_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         bank_q  <= '0;
         nraw_q  <= '0;
         relu_q  <= 1'b0;
         comp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         if (latch_en) begin
            bank_q <= results_i;
            nraw_q <= n_lanes_i;
            relu_q <= relu_i;
            comp_q <= compress_i;
         end
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_neur_out_seq.sv
// Directed bench for the neuron result drain sequencer.
module tb_neur_out_seq;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         start_i;
   logic [127:0] results_i;
   logic [1:0]   n_lanes_i;
   logic         relu_i;
   logic         compress_i;
   logic         flush_i;
   logic         out_valid_o;
   logic [31:0]  out_data_o;
   logic         out_ready_i;
   logic         busy_o;
   logic         done_o;

   int tests = 0;
   int fails = 0;

   localparam logic [127:0] RES = {32'h00001234, 32'hFFFFFF00, 32'h00015678, 32'h7FFF0009};

   neur_out_seq dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .results_i   (results_i),
      .n_lanes_i   (n_lanes_i),
      .relu_i      (relu_i),
      .compress_i  (compress_i),
      .flush_i     (flush_i),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
      chk({tag, "_busy"},  32'(busy_o),      32'd0);
      chk({tag, "_done"},  32'(done_o),      32'd0);
   endtask

   // Drive a start for one edge; returns at the negedge of cycle T+1.
   task automatic start_drain(input logic [1:0] n, input logic relu, input logic comp);
      @(negedge clk_i);
      start_i    = 1'b1;
      results_i  = RES;
      n_lanes_i  = n;
      relu_i     = relu;
      compress_i = comp;
      @(negedge clk_i);
      start_i    = 1'b0;
   endtask

   // Check words first..cnt-1 one per cycle, then the done pulse and return to idle.
   task automatic expect_words(input string tag, input logic [127:0] w, input int first, input int cnt);
      for (int i = first; i < cnt; i++) begin
         if (i > first) @(negedge clk_i);
         chk($sformatf("%s_w%0d_valid", tag, i), 32'(out_valid_o), 32'd1);
         chk($sformatf("%s_w%0d_data", tag, i),  out_data_o, w[127-32*i -: 32]);
      end
      @(negedge clk_i);
      chk({tag, "_done"},       32'(done_o),      32'd1);
      chk({tag, "_done_busy"},  32'(busy_o),      32'd1);
      chk({tag, "_done_valid"}, 32'(out_valid_o), 32'd0);
      @(negedge clk_i);
      chk_idle({tag, "_after"});
   endtask

   initial begin
      rst_ni      = 1'b0;
      start_i     = 1'b0;
      results_i   = '0;
      n_lanes_i   = 2'd0;
      relu_i      = 1'b0;
      compress_i  = 1'b0;
      flush_i     = 1'b0;
      out_ready_i = 1'b1;
      #1;
      chk_idle("reset");
      chk("reset_data", out_data_o, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Uncompressed, no relu, four lanes
      start_drain(2'd0, 1'b0, 1'b0);
      expect_words("unc4", {32'h00001234, 32'hFFFFFF00, 32'h00015678, 32'h7FFF0009}, 0, 4);

      // Compressed with relu, four lanes
      start_drain(2'd0, 1'b1, 1'b1);
      expect_words("cmp4r", {32'h12340000, 32'h56780009, 64'h0}, 0, 2);

      // Compressed, three lanes: odd tail zero-padded
      start_drain(2'd3, 1'b0, 1'b1);
      expect_words("cmp3", {32'h1234FF00, 32'h56780000, 64'h0}, 0, 2);

      // Uncompressed, one lane
      start_drain(2'd1, 1'b1, 1'b0);
      expect_words("unc1", {32'h00001234, 96'h0}, 0, 1);

      // Backpressure on word 1 for three cycles
      start_drain(2'd0, 1'b0, 1'b0);
      chk("bp_w0", out_data_o, 32'h00001234);
      @(negedge clk_i);
      out_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk_i);
         chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid_o), 32'd1);
         chk($sformatf("bp_hold%0d_data", i),  out_data_o, 32'hFFFFFF00);
      end
      out_ready_i = 1'b1;
      @(negedge clk_i);
      expect_words("bp", {32'h00001234, 32'hFFFFFF00, 32'h00015678, 32'h7FFF0009}, 2, 4);

      // Flush after the first transfer, then replay
      start_drain(2'd0, 1'b0, 1'b0);
      @(negedge clk_i);
      chk("fl_w1", out_data_o, 32'hFFFFFF00);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      chk_idle("fl_next");
      @(negedge clk_i);
      chk_idle("fl_next2");
      start_drain(2'd0, 1'b0, 1'b0);
      expect_words("replay", {32'h00001234, 32'hFFFFFF00, 32'h00015678, 32'h7FFF0009}, 0, 4);

      // Start together with flush in IDLE is ignored
      @(negedge clk_i);
      start_i = 1'b1;
      flush_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      flush_i = 1'b0;
      chk_idle("stfl");

      // Start during DRAIN with a different bank is ignored
      out_ready_i = 1'b0;
      start_drain(2'd0, 1'b0, 1'b0);
      start_i    = 1'b1;
      results_i  = {4{32'hAAAAAAAA}};
      n_lanes_i  = 2'd1;
      compress_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("ign_data",  out_data_o, 32'h00001234);
      chk("ign_valid", 32'(out_valid_o), 32'd1);
      out_ready_i = 1'b1;
      expect_words("ign", {32'h00001234, 32'hFFFFFF00, 32'h00015678, 32'h7FFF0009}, 0, 4);

      // Reset asserted mid-drain clears outputs immediately
      start_drain(2'd0, 1'b0, 1'b0);
      @(negedge clk_i);
      chk("rst_pre_valid", 32'(out_valid_o), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk_idle("rst_mid");
      chk("rst_mid_data", out_data_o, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk_idle("rst_after");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
